branch_resolve_tracker: RTL and testbench

Tracks each fetched instruction's branch prediction from fetch to execute, compares it against the resolved outcome in EX, and drives pipeline recovery. It consumes `prediction` from the branch history table and the predicted target from fetch, and produces the table's update strobe, index, `was_taken` and `jumped`. It sits beside the IF/ID/EX pipeline registers and raises flush/redirect on a mispredict.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/branch_resolve_tracker_slot.sv | 27 ++
 rtl/branch_resolve_tracker.sv | 132 +++++++++++++
 tb/tb_branch_resolve_tracker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve tracker.
//   state_e  : recovery FSM states
//   slot_t   : one tracking slot {valid, pc, pred_taken, pred_target}
//   sat_inc  : 32-bit saturating increment used by the statistics counters
package branch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  // Slot PC fields are sized for the widest supported PC.
  localparam int unsigned SLOT_PC_W   = 64;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_PC_W-1:0] pc;
    logic                 pred_taken;
    logic [SLOT_PC_W-1:0] pred_target;
  } slot_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_tracker_slot.sv
// bp_slot_reg: one prediction tracking slot.
//   clk, rst : clock, synchronous active-high reset
//   hold     : keep current contents
//   inval    : clear the valid bit (wins over hold and load)
//   d / q    : next slot contents / registered slot
module bp_slot_reg
  import branch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  inval,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inval) begin
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: follows each fetched prediction through ID and EX,
// checks it against the EX outcome, updates the BHT and drives recovery.
//   clk, rst              : clock, synchronous active-high reset
//   stall                 : pipeline hold
//   if_*                  : fetched instruction and its prediction
//   ex_*                  : resolved outcome of the EX instruction
//   bht_*                 : registered table update (single-cycle bht_en)
//   flush, redirect_*     : registered recovery request (single-cycle pulse)
//   branch_count          : saturating count of table updates
//   mispredict_count      : saturating count of mispredicts
//
// state   | meaning
// RUN     | normal operation, fetched instructions are captured
// RECOVER | cycle after a mispredict, the in-flight fetch is wrong-path
module branch_resolve_tracker
  import branch_pkg::*;
#(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned LOWER = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             if_pred_taken,
  input  logic [PC_W-1:0]  if_pred_target,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             bht_en,
  output logic [LOWER-1:0] bht_write_addr,
  output logic             bht_was_taken,
  output logic             bht_jumped,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  state_e state_q, state_next;
  slot_t  id_d, id_q, ex_q;

  logic            resolve, actual_taken, mispredict, update;
  logic [PC_W-1:0] ex_pc, ex_pred_target, correct_pc;

  always_comb begin
    id_d             = '0;
    id_d.valid       = if_valid && (state_q == RUN);
    id_d.pc          = SLOT_PC_W'(if_pc);
    id_d.pred_taken  = if_pred_taken;
    id_d.pred_target = SLOT_PC_W'(if_pred_target);
  end

  bp_slot_reg u_id_slot (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .inval (mispredict),
    .d     (id_d),
    .q     (id_q)
  );

  bp_slot_reg u_ex_slot (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .inval (mispredict),
    .d     (id_q),
    .q     (ex_q)
  );

  // A jump wins when both type flags are set, so it is always actual-taken.
  always_comb begin
    ex_pc          = ex_q.pc[PC_W-1:0];
    ex_pred_target = ex_q.pred_target[PC_W-1:0];
    resolve        = ex_q.valid && !stall;
    actual_taken   = ex_is_jump || (ex_is_branch && ex_taken);
    correct_pc     = actual_taken ? ex_target : ex_pc + PC_W'(INSTR_BYTES);
    mispredict     = resolve &&
                     ((actual_taken != ex_q.pred_taken) ||
                      (actual_taken && (ex_pred_target != ex_target)));
    update         = resolve && (ex_is_branch || ex_is_jump);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      RUN:     if (mispredict) state_next = RECOVER;
      RECOVER: if (!stall)     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Pulses are recomputed every cycle so stall can never stretch them;
  // address/target fields keep the last reported value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_en           <= 1'b0;
      bht_write_addr   <= '0;
      bht_was_taken    <= 1'b0;
      bht_jumped       <= 1'b0;
      flush            <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      bht_en         <= update;
      flush          <= mispredict;
      redirect_valid <= mispredict;
      if (update) begin
        bht_write_addr <= ex_pc[LOWER+1:2];
        bht_was_taken  <= ex_is_branch && ex_taken && !ex_is_jump;
        bht_jumped     <= ex_is_jump;
        branch_count   <= sat_inc(branch_count);
      end
      if (mispredict) begin
        redirect_pc      <= correct_pc;
        mispredict_count <= sat_inc(mispredict_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
module tb_branch_resolve_tracker;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, if_valid, if_pred_taken;
  logic [63:0] if_pc, if_pred_target, ex_target;
  logic        ex_is_branch, ex_is_jump, ex_taken;
  logic        bht_en, bht_was_taken, bht_jumped, flush, redirect_valid;
  logic [4:0]  bht_write_addr;
  logic [63:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_tracker #(.PC_W(64), .LOWER(5)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
    .bht_jumped(bht_jumped), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: in-flight instructions as a 2-entry queue (oldest = EX).
  typedef struct {
    bit        v;
    bit [63:0] pc;
    bit        pt;
    bit [63:0] ptgt;
  } ent_t;

  ent_t      mq[$];
  bit        m_recover;
  bit        e_en, e_wt, e_j, e_flush;
  bit [4:0]  e_addr;
  bit [63:0] e_rpc;
  bit [31:0] e_bc, e_mc;

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 0; e.pc = 0; e.pt = 0; e.ptgt = 0;
    return e;
  endfunction

  task automatic model_flush_queue();
    mq.delete();
    mq.push_back(empty_ent());
    mq.push_back(empty_ent());
  endtask

  task automatic model_step();
    ent_t old, nw;
    bit at, mp;
    bit [63:0] npc;
    e_en = 0; e_flush = 0;
    if (rst) begin
      model_flush_queue();
      m_recover = 0;
      e_addr = 0; e_wt = 0; e_j = 0; e_rpc = 0; e_bc = 0; e_mc = 0;
      return;
    end
    if (stall) return;
    old = mq[0];
    if (old.v) begin
      at  = ex_is_jump || (ex_is_branch && ex_taken);
      npc = at ? ex_target : old.pc + 64'd4;
      mp  = (at != old.pt) || (at && old.ptgt != ex_target);
      if (ex_is_branch || ex_is_jump) begin
        e_en   = 1;
        e_addr = old.pc[6:2];
        e_wt   = ex_is_branch && ex_taken && !ex_is_jump;
        e_j    = ex_is_jump;
        if (e_bc != 32'hFFFF_FFFF) e_bc++;
      end
      if (mp) begin
        e_flush = 1;
        e_rpc   = npc;
        if (e_mc != 32'hFFFF_FFFF) e_mc++;
        model_flush_queue();
        m_recover = 1;
        return;
      end
    end
    nw.v = if_valid && !m_recover; nw.pc = if_pc; nw.pt = if_pred_taken; nw.ptgt = if_pred_target;
    void'(mq.pop_front());
    mq.push_back(nw);
    m_recover = 0;
  endtask

  task automatic check_model();
    chk("m_bht_en", bht_en, e_en);
    chk("m_flush", flush, e_flush);
    chk("m_redirect_valid", redirect_valid, e_flush);
    chk("m_branch_count", branch_count, e_bc);
    chk("m_mispredict_count", mispredict_count, e_mc);
    if (e_en) begin
      chk("m_addr", bht_write_addr, e_addr);
      chk("m_was_taken", bht_was_taken, e_wt);
      chk("m_jumped", bht_jumped, e_j);
    end
    if (e_flush) chk("m_redirect_pc", redirect_pc, e_rpc);
  endtask

  // Inputs are set at a falling edge; outputs are checked at the next one.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; if_valid = 0; if_pc = 0; if_pred_taken = 0; if_pred_target = 0;
    ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_target = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Fetch one instruction and move it into EX.
  task automatic feed(input logic [63:0] pc, input logic pt, input logic [63:0] ptgt);
    if_valid = 1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
    step();
    if_valid = 0;
    step();
  endtask

  task automatic resolve(input logic br, input logic jmp, input logic tk, input logic [63:0] tgt);
    ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk; ex_target = tgt;
    step();
    ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_target = 0;
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        pt;
    logic [63:0] ptgt;
    logic        br, jmp, tk;
    logic [63:0] tgt;
    logic        en;
    logic [4:0]  addr;
    logic        wt, j, fl;
    logic [63:0] rpc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{64'h40,  1'b0, 64'h0,   1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[1] = '{64'h80,  1'b0, 64'h0,   1'b1, 1'b0, 1'b1, 64'h20,  1'b1, 5'h00, 1'b1, 1'b0, 1'b1, 64'h20};
    vecs[2] = '{64'h100, 1'b1, 64'h200, 1'b0, 1'b1, 1'b0, 64'h300, 1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 64'h300};
    vecs[3] = '{64'h44,  1'b1, 64'h90,  1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 64'h48};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b0, 64'h1000,
                1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[5] = '{64'h60,  1'b1, 64'h500, 1'b1, 1'b0, 1'b1, 64'h500, 1'b1, 5'h18, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[6] = '{64'h10,  1'b1, 64'h30,  1'b1, 1'b1, 1'b0, 64'h30,  1'b1, 5'h04, 1'b0, 1'b1, 1'b0, 64'h0};

    model_flush_queue();
    m_recover = 0;
    @(negedge clk);
    do_reset();

    chk("reset_bht_en", bht_en, 0);
    chk("reset_addr", bht_write_addr, 0);
    chk("reset_was_taken", bht_was_taken, 0);
    chk("reset_jumped", bht_jumped, 0);
    chk("reset_flush", flush, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_branch_count", branch_count, 0);
    chk("reset_mispredict_count", mispredict_count, 0);

    // Table-driven single-instruction cases.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      feed(vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
      resolve(vecs[i].br, vecs[i].jmp, vecs[i].tk, vecs[i].tgt);
      chk($sformatf("vec%0d_bht_en", i), bht_en, vecs[i].en);
      chk($sformatf("vec%0d_flush", i), flush, vecs[i].fl);
      chk($sformatf("vec%0d_redirect_valid", i), redirect_valid, vecs[i].fl);
      chk($sformatf("vec%0d_branch_count", i), branch_count, {31'b0, vecs[i].en});
      chk($sformatf("vec%0d_mispredict_count", i), mispredict_count, {31'b0, vecs[i].fl});
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_addr", i), bht_write_addr, vecs[i].addr);
        chk($sformatf("vec%0d_was_taken", i), bht_was_taken, vecs[i].wt);
        chk($sformatf("vec%0d_jumped", i), bht_jumped, vecs[i].j);
      end
      if (vecs[i].fl) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].rpc);
    end

    // Stall held across resolution: exactly one pulse after stall drops.
    do_reset();
    feed(64'h40, 1'b0, 64'h0);
    ex_is_branch = 1; ex_taken = 0; stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_no_update", bht_en, 0);
    end
    stall = 0;
    step();
    chk("stall_release_update", bht_en, 1);
    chk("stall_release_addr", bht_write_addr, 5'h10);
    ex_is_branch = 0;
    step();
    chk("stall_single_pulse", bht_en, 0);
    chk("stall_branch_count", branch_count, 1);

    // Fetch in the RECOVER cycle must never reach EX.
    do_reset();
    feed(64'h80, 1'b0, 64'h0);
    resolve(1'b1, 1'b0, 1'b1, 64'h20);
    chk("recover_flush", flush, 1);
    if_valid = 1; if_pc = 64'h44; if_pred_taken = 1; if_pred_target = 64'h90;
    step();
    chk("recover_pulse_drop", flush, 0);
    if_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("recover_no_wrong_path", flush, 0);
    end
    chk("recover_mispredict_count", mispredict_count, 1);

    // Reset while in RECOVER.
    do_reset();
    feed(64'h80, 1'b0, 64'h0);
    resolve(1'b1, 1'b0, 1'b1, 64'h20);
    chk("rr_state_recover", dut.state_q, RECOVER);
    rst = 1; stall = 1; if_valid = 1; if_pc = 64'h8; if_pred_taken = 1;
    step();
    chk("rr_state", dut.state_q, RUN);
    chk("rr_flush", flush, 0);
    chk("rr_redirect_pc", redirect_pc, 0);
    chk("rr_mispredict_count", mispredict_count, 0);
    idle_inputs();
    step();
    step();
    chk("rr_no_update", bht_en, 0);

    // Counter saturation.
    do_reset();
    force dut.mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_count;
    e_mc = 32'hFFFF_FFFF;
    feed(64'h80, 1'b0, 64'h0);
    resolve(1'b1, 1'b0, 1'b1, 64'h20);
    chk("sat_flush", flush, 1);
    chk("sat_mispredict_count", mispredict_count, 32'hFFFF_FFFF);

    // Randomized traffic against the queue model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(0, 99) < 2);
      stall          = ($urandom_range(0, 3) == 0);
      if_valid       = ($urandom_range(0, 3) != 0);
      if_pc          = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 9) == 0) if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      if_pred_taken  = $urandom_range(0, 1);
      if_pred_target = {32'h0, $urandom} & ~64'h3;
      ex_is_branch   = $urandom_range(0, 1);
      ex_is_jump     = ($urandom_range(0, 3) == 0);
      ex_taken       = $urandom_range(0, 1);
      ex_target      = ($urandom_range(0, 1) == 1) ? mq[0].ptgt : ({32'h0, $urandom} & ~64'h3);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
